// File: rtl/decryption_pkg.sv
// Shared register-map constants for the decryption register bank.
// Offsets, CTRL/STATUS bit positions, cipher encodings and key stride.
package decryption_pkg;

  localparam int SELECT_OFFSET = 'h00;
  localparam int CTRL_OFFSET   = 'h02;
  localparam int STATUS_OFFSET = 'h04;
  localparam int KEY_STRIDE    = 2;

  localparam int CTRL_COMMIT   = 0;
  localparam int CTRL_LOCK     = 1;

  localparam int STAT_PENDING  = 0;
  localparam int STAT_LOCKED   = 1;
  localparam int STAT_BUSY     = 2;

  typedef enum logic [1:0] {
    SEL_CAESAR  = 2'd0,
    SEL_SCYTALE = 2'd1,
    SEL_ZIGZAG  = 2'd2
  } cipher_sel_e;

endpackage

// File: rtl/decryption_key_slot.sv
// Shadow/active register pair: writes land in the shadow,
// a transfer copies the pre-edge shadow into the active copy.
module decryption_key_slot #(
  parameter int             W         = 16,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         transfer,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] shadow,
  output logic [W-1:0] active
);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RESET_VAL;
      active <= RESET_VAL;
    end else begin
      if (load)     shadow <= wdata;
      if (transfer) active <= shadow;
    end
  end

endmodule

// File: rtl/decryption_regbank.sv
// Register bank holding cipher select and keys, with shadowed
// updates committed to the engine only while it is idle.
module decryption_regbank
  import decryption_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 16,
  parameter int NUM_KEYS   = 3,
  parameter logic [ADDR_WIDTH-1:0] KEY_BASE = 8'h10,
  parameter logic [NUM_KEYS*REG_WIDTH-1:0] KEY_RESET =
    {16'h0002, 16'hFFFF, 16'h0000}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic                          read,
  input  logic                          write,
  input  logic [REG_WIDTH-1:0]          wdata,
  input  logic                          engine_busy,
  output logic [REG_WIDTH-1:0]          rdata,
  output logic                          done,
  output logic                          error,
  output logic [REG_WIDTH-1:0]          select,
  output logic [NUM_KEYS*REG_WIDTH-1:0] key_bus,
  output logic                          key_update
);

  logic                 pending;
  logic                 locked;
  logic                 sel_hit;
  logic                 ctrl_hit;
  logic                 stat_hit;
  logic                 key_hit;
  logic [NUM_KEYS-1:0]  key_sel;
  logic [REG_WIDTH-1:0] key_rd;
  logic [REG_WIDTH-1:0] sel_shadow;
  logic [REG_WIDTH-1:0] stat_val;
  logic [REG_WIDTH-1:0] ctrl_val;
  logic [REG_WIDTH-1:0] rd_val;
  logic [REG_WIDTH-1:0] key_shadow [NUM_KEYS];
  logic                 sel_ok;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 acc_err;
  logic                 commit;
  logic                 lock_set;
  logic                 xfer;

  assign sel_hit  = addr == ADDR_WIDTH'(SELECT_OFFSET);
  assign ctrl_hit = addr == ADDR_WIDTH'(CTRL_OFFSET);
  assign stat_hit = addr == ADDR_WIDTH'(STATUS_OFFSET);

  always_comb begin
    key_sel = '0;
    key_rd  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (addr == ADDR_WIDTH'(int'(KEY_BASE) + KEY_STRIDE * i)) begin
        key_sel[i] = 1'b1;
        key_rd     = key_shadow[i];
      end
    end
  end

  assign key_hit = |key_sel;

  // Commit writes to CTRL stay legal while locked.
  assign sel_ok = wdata < REG_WIDTH'(NUM_KEYS);
  assign wr_ok  = write & ~read &
                  ((sel_hit & sel_ok & ~locked) |
                   (key_hit & ~locked) |
                   (ctrl_hit & (~locked | wdata[CTRL_COMMIT])));
  assign rd_ok  = read & ~write &
                  (sel_hit | ctrl_hit | stat_hit | key_hit);

  assign acc_err  = (read | write) & ~(wr_ok | rd_ok);
  assign commit   = wr_ok & ctrl_hit & wdata[CTRL_COMMIT];
  assign lock_set = wr_ok & ctrl_hit & wdata[CTRL_LOCK];
  assign xfer     = pending & ~engine_busy;

  always_comb begin
    stat_val               = '0;
    stat_val[STAT_PENDING] = pending;
    stat_val[STAT_LOCKED]  = locked;
    stat_val[STAT_BUSY]    = engine_busy;
    ctrl_val               = '0;
    ctrl_val[CTRL_LOCK]    = locked;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_hit:  rd_val = sel_shadow;
      ctrl_hit: rd_val = ctrl_val;
      stat_hit: rd_val = stat_val;
      key_hit:  rd_val = key_rd;
      default:  rd_val = '0;
    endcase
  end

  decryption_key_slot #(
    .W         (REG_WIDTH),
    .RESET_VAL (REG_WIDTH'(SEL_CAESAR))
  ) u_select (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_ok & sel_hit),
    .transfer (xfer),
    .wdata    (wdata),
    .shadow   (sel_shadow),
    .active   (select)
  );

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    decryption_key_slot #(
      .W         (REG_WIDTH),
      .RESET_VAL (KEY_RESET[i*REG_WIDTH +: REG_WIDTH])
    ) u_key (
      .clk      (clk),
      .rst      (rst),
      .load     (wr_ok & key_sel[i]),
      .transfer (xfer),
      .wdata    (wdata),
      .shadow   (key_shadow[i]),
      .active   (key_bus[i*REG_WIDTH +: REG_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      locked     <= 1'b0;
      rdata      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      key_update <= 1'b0;
    end else begin
      done       <= read | write;
      error      <= acc_err;
      key_update <= xfer;
      if (rd_ok)
        rdata <= rd_val;
      else if (read & ~write)
        rdata <= '0;
      // A commit while already pending is absorbed.
      pending <= (pending & ~xfer) | (commit & ~pending);
      if (lock_set) locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decryption_regbank.sv
// Directed and random checks of decryption_regbank against
// a behavioural register-map model.
module tb_decryption_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic        read;
  logic        write;
  logic [15:0] wdata;
  logic        engine_busy;
  logic [15:0] rdata;
  logic        done;
  logic        error;
  logic [15:0] select;
  logic [47:0] key_bus;
  logic        key_update;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_sh  [3];
  logic [15:0] m_act [3];
  logic [15:0] m_sel_sh, m_sel_act;
  bit          m_pend, m_lock;
  logic [15:0] e_rdata;
  bit          e_done, e_err, e_kupd;

  decryption_regbank dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .read        (read),
    .write       (write),
    .wdata       (wdata),
    .engine_busy (engine_busy),
    .rdata       (rdata),
    .done        (done),
    .error       (error),
    .select      (select),
    .key_bus     (key_bus),
    .key_update  (key_update)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int key_idx(input logic [7:0] a);
    for (int i = 0; i < 3; i++)
      if (a == 8'h10 + 8'(2 * i)) return i;
    return -1;
  endfunction

  task automatic model_step(input bit rs, input bit r, input bit w,
                            input logic [7:0] a, input logic [15:0] wd,
                            input bit busy);
    int  k;
    bit  mapped, bad, old_pend;
    if (rs) begin
      m_sh  = '{16'h0000, 16'hFFFF, 16'h0002};
      m_act = '{16'h0000, 16'hFFFF, 16'h0002};
      m_sel_sh = 0; m_sel_act = 0;
      m_pend = 0; m_lock = 0;
      e_done = 0; e_err = 0; e_rdata = 0; e_kupd = 0;
      return;
    end
    k      = key_idx(a);
    mapped = (a == 8'h00) || (a == 8'h02) || (a == 8'h04) || (k >= 0);
    e_done = r || w;
    e_kupd = m_pend && !busy;
    if (r && w)        bad = 1;
    else if (!mapped)  bad = 1;
    else if (w) begin
      if (a == 8'h04)      bad = 1;
      else if (a == 8'h00) bad = (wd >= 3) || m_lock;
      else if (a == 8'h02) bad = m_lock && !wd[0];
      else                 bad = m_lock;
    end else bad = 0;
    e_err = (r || w) && bad;
    if (r && !w) begin
      if (bad)             e_rdata = 0;
      else if (a == 8'h00) e_rdata = m_sel_sh;
      else if (a == 8'h02) e_rdata = m_lock ? 16'd2 : 16'd0;
      else if (a == 8'h04)
        e_rdata = 16'(m_pend) + 16'(m_lock) * 2 + 16'(busy) * 4;
      else                 e_rdata = m_sh[k];
    end
    old_pend = m_pend;
    if (old_pend && !busy) begin
      m_act = m_sh;
      m_sel_act = m_sel_sh;
      m_pend = 0;
    end
    if (w && !r && !bad) begin
      if (a == 8'h00)   m_sel_sh = wd;
      else if (k >= 0)  m_sh[k] = wd;
      else if (a == 8'h02) begin
        if (wd[0] && !old_pend) m_pend = 1;
        if (wd[1]) m_lock = 1;
      end
    end
  endtask

  task automatic cyc(input bit rs, input bit r, input bit w,
                     input logic [7:0] a, input logic [15:0] wd,
                     input bit busy);
    rst = rs; read = r; write = w; addr = a; wdata = wd;
    engine_busy = busy;
    @(posedge clk);
    model_step(rs, r, w, a, wd, busy);
    #1;
    chk("done", 64'(done), 64'(e_done));
    chk("error", 64'(error), 64'(e_err));
    chk("rdata", 64'(rdata), 64'(e_rdata));
    chk("key_update", 64'(key_update), 64'(e_kupd));
    chk("key_bus", 64'(key_bus), 64'({m_act[2], m_act[1], m_act[0]}));
    chk("select", 64'(select), 64'(m_sel_act));
  endtask

  initial begin
    logic [7:0] alist [16];
    bit r, w, b, rs;
    logic [7:0]  a;
    logic [15:0] wd;
    alist = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0E, 8'h10, 8'h11,
              8'h12, 8'h13, 8'h14, 8'h16, 8'h01, 8'hFF, 8'h10, 8'h00};

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_keys", 64'(key_bus), 64'h0002_FFFF_0000);
    chk("reset_rdata", 64'(rdata), 64'h0);

    cyc(0, 0, 1, 8'h10, 16'h0005, 0);
    cyc(0, 1, 0, 8'h10, 0, 0);
    chk("key0_read", 64'(rdata), 64'h0005);
    chk("key0_active", 64'(key_bus[15:0]), 64'h0000);

    cyc(0, 0, 1, 8'h02, 16'h0001, 1);
    cyc(0, 1, 0, 8'h04, 0, 1);
    chk("status_busy", 64'(rdata), 64'h0005);
    chk("no_upd_busy", 64'(key_update), 64'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("upd_pulse", 64'(key_update), 64'h1);
    chk("key0_xfer", 64'(key_bus[15:0]), 64'h0005);
    cyc(0, 1, 0, 8'h04, 0, 0);
    chk("upd_end", 64'(key_update), 64'h0);
    chk("status_clr", 64'(rdata), 64'h0000);

    cyc(0, 0, 1, 8'h00, 16'd3, 0);
    chk("sel_range", 64'(error), 64'h1);
    cyc(0, 1, 0, 8'h06, 0, 0);
    chk("unmapped", 64'(error), 64'h1);
    chk("unmapped_rd", 64'(rdata), 64'h0);
    cyc(0, 1, 1, 8'h00, 16'd1, 0);
    chk("rw_both", 64'(error), 64'h1);
    cyc(0, 1, 0, 8'h00, 0, 0);
    chk("sel_shadow", 64'(rdata), 64'h0);

    cyc(0, 0, 1, 8'h02, 16'h0002, 0);
    cyc(0, 0, 1, 8'h12, 16'h1234, 0);
    chk("locked_wr", 64'(error), 64'h1);
    cyc(0, 1, 0, 8'h12, 0, 0);
    chk("key1_kept", 64'(rdata), 64'hFFFF);
    cyc(0, 0, 1, 8'h02, 16'h0001, 0);
    chk("locked_commit", 64'(error), 64'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("locked_upd", 64'(key_update), 64'h1);

    cyc(0, 0, 1, 8'h02, 16'h0001, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_no_upd", 64'(key_update), 64'h0);
    chk("rst_keys", 64'(key_bus), 64'h0002_FFFF_0000);
    cyc(0, 1, 0, 8'h04, 0, 0);
    chk("rst_pend", 64'(rdata), 64'h0);

    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 59) == 0);
      r  = ($urandom_range(0, 2) == 0);
      w  = ($urandom_range(0, 1) == 0);
      b  = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                       : alist[$urandom_range(0, 15)];
      wd = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3))
                                       : 16'($urandom);
      if (a == 8'h02 && wd[1] && $urandom_range(0, 7) != 0)
        wd[1] = 1'b0;
      cyc(rs, r, w, a, wd, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
